truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Controller that sequences a 7-input combinational classification function (x0..x6 -> out).
- Drives all 128 input vectors in ascending order and samples the function output for each.
- Assembles the 128-bit truth table and its ones count, and compares the table against an expected signature.
- Sits between the bench/host and any single-output 7-input function block; result is returned over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, idle cycles between driving a vector and sampling f_in (range 0..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; accepted only in IDLE
abort  input  1  terminate sweep, return to IDLE without result
x_drv  output  7  input vector to the function block; bit k drives xk
f_in  input  1  function output (out) for the current x_drv
expect_tt  input  128  expected truth table, sampled when start is accepted
busy  output  1  high in DRIVE or WAIT
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
truth_table  output  128  bit i = f(x_drv == i); bit 127 is MSB
ones_count  output  8  number of ones in truth_table (0..128)
match  output  1  truth_table == captured expect_tt

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; x_drv=0, busy=0, res_valid=0, truth_table=0, ones_count=0, match=0, internal expect register=0, wait counter=0.
- States: IDLE, DRIVE, WAIT, HOLD.
- IDLE:
  - start=1 at edge E0: capture expect_tt; clear truth_table and ones_count; x_drv=0; go to DRIVE (or WAIT if SETTLE_CYCLES>0).
  - Outputs truth_table, ones_count and match keep their last values until the next accepted start.
- WAIT: counts SETTLE_CYCLES cycles, then goes to DRIVE.
- DRIVE:
  - At the edge, truth_table[x_drv] <= f_in and ones_count += f_in.
  - If x_drv != 127: x_drv increments and the state returns to WAIT (or stays in DRIVE if SETTLE_CYCLES=0).
  - If x_drv == 127: the state goes to HOLD and x_drv returns to 0.
- Timing: vector i is sampled at edge E0 + (i+1)*(SETTLE_CYCLES+1). res_valid rises in the cycle after edge E0 + 128*(SETTLE_CYCLES+1).
- match is registered together with res_valid and uses the final truth_table, including the bit-127 sample.
- HOLD:
  - res_valid=1; outputs stable.
  - res_valid & res_ready at an edge: res_valid=0, go to IDLE.
  - start is ignored while in HOLD.
- ones_count: 8-bit unsigned; never wraps, since its maximum is 128.
- abort=1 in DRIVE/WAIT: next edge goes to IDLE; x_drv=0, busy=0, res_valid stays 0; partial truth_table/ones_count remain visible; match=0.
- abort in IDLE/HOLD: ignored.
- abort has priority over a sample in the same cycle: the bit is not written.
- start asserted while busy: ignored.
- start and abort both high in IDLE: start wins.
- Reset mid-sweep: immediate return to reset values; no result is produced.
- x_drv changes only on clock edges and is glitch-free registered.

Test Plan:
- SETTLE_CYCLES=0, f_in=x_drv[0], expect_tt=0xAAAA_..._AAAA -> res_valid exactly 129 cycles after start; truth_table=0xAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA; ones_count=64; match=1.
- SETTLE_CYCLES=2, f_in=AND of x_drv[6:0], expect_tt=0 -> truth_table=0x80000000000000000000000000000000; ones_count=1; match=0; res_valid at cycle 3*128+1=385.
- f_in=majority network (w0..w6 chain), expect_tt=0xfeeeeee8faa8e8a0fae8eaa0e8888880 -> match=1; ones_count equals popcount of that value.
- res_ready held low for 20 cycles after res_valid -> outputs stable, start pulses ignored; res_ready=1 -> res_valid drops next edge, state IDLE.
- abort asserted when x_drv=40 -> busy=0 next cycle, x_drv=0, res_valid never rises, bits 40..127 remain 0.
- rst_n pulsed low asynchronously mid-sweep (between edges) -> all outputs zero immediately; a new start then completes a full normal sweep.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//   Sequences a single-output 7-input combinational function block through
//   all 128 input vectors in ascending order. It samples the function output
//   for each vector, builds the 128-bit truth table and its ones count, and
//   compares the table against an expected signature that is captured at
//   start. The result is returned over a valid/ready handshake.
//
// Parameters:
//   SETTLE_CYCLES - idle cycles between driving a vector and sampling f_in
//                   (0..15)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a sweep (accepted only when idle)
//   abort        in   stop a running sweep and return to idle, no result
//   x_drv        out  [6:0] vector driven to the function block (bit k -> xk)
//   f_in         in   function output for the current x_drv
//   expect_tt    in   [127:0] expected truth table, captured on start
//   busy         out  high while the sweep is driving or settling
//   res_valid    out  result available
//   res_ready    in   consumer accepts the result
//   truth_table  out  [127:0] bit i = f(i)
//   ones_count   out  [7:0] number of ones in truth_table
//   match        out  truth_table equals the captured expect_tt
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic [6:0]   x_drv,
    input  logic         f_in,
    input  logic [127:0] expect_tt,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] truth_table,
    output logic [7:0]   ones_count,
    output logic         match
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // With no settle time the WAIT state is never entered: every new vector
    // is sampled on the very next edge.
    localparam bit         HAS_WAIT  = (SETTLE_CYCLES != 0);
    localparam logic [3:0] LAST_WAIT = HAS_WAIT ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [1:0] NEXT_VEC  = HAS_WAIT ? S_WAIT : S_DRIVE;

    logic [1:0]   state_q, state_d;
    logic [6:0]   x_q, x_d;
    logic [127:0] tt_q, tt_d;
    logic [7:0]   ones_q, ones_d;
    logic         match_q, match_d;
    logic         valid_q, valid_d;
    logic [127:0] exp_q, exp_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] tt_sampled;

    // Next-state logic. tt_sampled is the table with the current sample
    // merged in, so the final compare already includes the bit-127 sample.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        tt_d       = tt_q;
        ones_d     = ones_q;
        match_d    = match_q;
        valid_d    = valid_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        tt_sampled = tt_q;
        tt_sampled[x_q] = f_in;

        case (state_q)
            S_IDLE: begin
                // start wins over abort when both are high here
                if (start) begin
                    exp_d   = expect_tt;
                    tt_d    = '0;
                    ones_d  = '0;
                    match_d = 1'b0;
                    x_d     = '0;
                    cnt_d   = '0;
                    state_d = NEXT_VEC;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    x_d     = '0;
                    cnt_d   = '0;
                    match_d = 1'b0;
                end else if (cnt_q == LAST_WAIT) begin
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DRIVE: begin
                // abort takes priority: the pending sample is dropped
                if (abort) begin
                    state_d = S_IDLE;
                    x_d     = '0;
                    cnt_d   = '0;
                    match_d = 1'b0;
                end else begin
                    tt_d   = tt_sampled;
                    ones_d = ones_q + {7'd0, f_in};
                    if (x_q == 7'd127) begin
                        state_d = S_HOLD;
                        x_d     = '0;
                        valid_d = 1'b1;
                        match_d = (tt_sampled == exp_q);
                    end else begin
                        x_d     = x_q + 7'd1;
                        cnt_d   = '0;
                        state_d = NEXT_VEC;
                    end
                end
            end

            S_HOLD: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
            valid_q <= 1'b0;
            exp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            match_q <= match_d;
            valid_q <= valid_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_drv       = x_q;
    assign busy        = (state_q == S_DRIVE) || (state_q == S_WAIT);
    assign res_valid   = valid_q;
    assign truth_table = tt_q;
    assign ones_count  = ones_q;
    assign match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweepers are instantiated, one with no settle time and one with two
// settle cycles. Each drives its own copy of a bench-side function block.
// Sweeps are run on one instance at a time; the expected result of each
// sweep is derived directly from the function definition and queued when the
// sweep is started, and a monitor compares whenever a result appears.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam logic [127:0] MAJ_SIG = 128'hfeeeeee8faa8e8a0fae8eaa0e8888880;

    typedef struct {
        int           inst;
        logic [127:0] tt;
        logic [7:0]   ones;
        logic         match;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] exp_in;
    int           func_sel;
    logic [127:0] rnd_tt;

    logic         start0, abort0, ready0, f0, busy0, valid0, match0;
    logic [6:0]   x0;
    logic [127:0] tt0;
    logic [7:0]   ones0;
    logic         start1, abort1, ready1, f1, busy1, valid1, match1;
    logic [6:0]   x1;
    logic [127:0] tt1;
    logic [7:0]   ones1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t cur;
    logic prev_valid[2];

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Cycle counter used to check when a result appears.
    always @(posedge clk) cyc <= cyc + 1;

    // Function definitions by selector: odd-parity of bit 0, 7-input AND,
    // the known majority-network table, and a random table.
    function automatic logic fref(input int func, input int i, input logic [127:0] rt);
        logic [127:0] sig;
        sig = MAJ_SIG;
        case (func)
            0:       return (i % 2) == 1;
            1:       return i == 127;
            2:       return sig[i];
            default: return rt[i];
        endcase
    endfunction

    // Expected result of a sweep covering vectors 0..upto-1.
    function automatic exp_t model(input int k, input int func, input logic [127:0] expv,
                                   input int upto, input logic [127:0] rt);
        exp_t e;
        e.inst = k;
        e.tt   = '0;
        e.ones = '0;
        for (int i = 0; i < upto; i++) begin
            if (fref(func, i, rt)) begin
                e.tt[i] = 1'b1;
                e.ones  = e.ones + 8'd1;
            end
        end
        e.match = (e.tt == expv);
        e.due   = 0;
        return e;
    endfunction

    // Bench-side function blocks, one per sweeper.
    assign f0 = fref(func_sel, int'(x0), rnd_tt);
    assign f1 = fref(func_sel, int'(x1), rnd_tt);

    truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .x_drv(x0),
        .f_in(f0), .expect_tt(exp_in), .busy(busy0), .res_valid(valid0),
        .res_ready(ready0), .truth_table(tt0), .ones_count(ones0), .match(match0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .x_drv(x1),
        .f_in(f1), .expect_tt(exp_in), .busy(busy1), .res_valid(valid1),
        .res_ready(ready1), .truth_table(tt1), .ones_count(ones1), .match(match1)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Result monitor for one instance: on a rising res_valid pop and compare
    // the whole result, and while it stays high check it does not move.
    task automatic monitorInst(input int k, input logic v, input logic [127:0] tt,
                               input logic [7:0] ones, input logic m);
        if (v && !prev_valid[k]) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result inst=%0d: got res_valid=1, required no result", k);
            end else begin
                cur = sb.pop_front();
                checkOutput("result_inst", 128'(k), 128'(cur.inst));
                checkOutput("valid_cycle", 128'(cyc), 128'(cur.due));
                checkOutput("truth_table", tt, cur.tt);
                checkOutput("ones_count", 128'(ones), 128'(cur.ones));
                checkOutput("match", 128'(m), 128'(cur.match));
            end
        end else if (v) begin
            checkOutput("hold_truth_table", tt, cur.tt);
            checkOutput("hold_ones_count", 128'(ones), 128'(cur.ones));
            checkOutput("hold_match", 128'(m), 128'(cur.match));
        end
        prev_valid[k] = v;
    endtask

    // Monitor process, sampling away from the active edge.
    always @(negedge clk) begin
        monitorInst(0, valid0, tt0, ones0, match0);
        monitorInst(1, valid1, tt1, ones1, match1);
    end

    // Starts a sweep on instance k and queues its expected result.
    task automatic applyStimulus(input int k, input int func, input logic [127:0] expv,
                                 input logic alsoAbort);
        exp_t e;
        @(negedge clk);
        func_sel = func;
        exp_in   = expv;
        e = model(k, func, expv, 128, rnd_tt);
        if (k == 0) begin start0 = 1'b1; abort0 = alsoAbort; end
        else        begin start1 = 1'b1; abort1 = alsoAbort; end
        @(posedge clk);
        #1;
        e.due = cyc + 128 * ((k == 0) ? 1 : 3);
        sb.push_back(e);
        start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
    endtask

    // Bounded wait for a result on instance k.
    task automatic waitResult(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k == 0) ? valid0 : valid1) == 1'b0 && n < 1000);
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout inst=%0d: got no res_valid, required one", k);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_x0"}, 128'(x0), '0);
        checkOutput({tag, "_busy0"}, 128'(busy0), '0);
        checkOutput({tag, "_valid0"}, 128'(valid0), '0);
        checkOutput({tag, "_tt0"}, tt0, '0);
        checkOutput({tag, "_ones0"}, 128'(ones0), '0);
        checkOutput({tag, "_match0"}, 128'(match0), '0);
        checkOutput({tag, "_x1"}, 128'(x1), '0);
        checkOutput({tag, "_busy1"}, 128'(busy1), '0);
        checkOutput({tag, "_valid1"}, 128'(valid1), '0);
        checkOutput({tag, "_tt1"}, tt1, '0);
        checkOutput({tag, "_ones1"}, 128'(ones1), '0);
        checkOutput({tag, "_match1"}, 128'(match1), '0);
    endtask

    // Main test sequence.
    initial begin
        exp_t p;
        int   n;
        logic [127:0] ev;
        int   bi;
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        exp_in = '0; func_sel = 0; rnd_tt = '0;
        prev_valid[0] = 1'b0; prev_valid[1] = 1'b0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] parity sweep, no settle");
        applyStimulus(0, 0, {32{4'hA}}, 1'b0);
        waitResult(0);

        $display("[TB] AND sweep, two settle cycles, stray start mid-sweep");
        applyStimulus(1, 1, '0, 1'b0);
        repeat (50) @(negedge clk);
        exp_in = '1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        waitResult(1);

        $display("[TB] majority table with start and abort together");
        applyStimulus(1, 2, MAJ_SIG, 1'b1);
        waitResult(1);
        applyStimulus(0, 2, MAJ_SIG, 1'b0);
        waitResult(0);

        $display("[TB] random tables");
        for (int r = 0; r < 4; r++) begin
            rnd_tt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ev = rnd_tt;
            if (r % 2 == 1) begin
                bi = $urandom_range(0, 127);
                ev[bi] = ~ev[bi];
            end
            applyStimulus(r % 2, 3, ev, 1'b0);
            waitResult(r % 2);
        end

        $display("[TB] held result with back-pressure");
        ready0 = 1'b0;
        applyStimulus(0, 3, rnd_tt, 1'b0);
        waitResult(0);
        for (int i = 0; i < 20; i++) begin
            start0 = (i % 2 == 0);
            @(negedge clk);
            checkOutput("hold_busy", 128'(busy0), '0);
            checkOutput("hold_valid", 128'(valid0), 128'(1));
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", 128'(valid0), '0);
        checkOutput("release_busy", 128'(busy0), '0);

        $display("[TB] abort at vector 40");
        rnd_tt = {$urandom(), $urandom(), $urandom(), $urandom()};
        applyStimulus(1, 3, rnd_tt, 1'b0);
        n = 0;
        while (x1 != 7'd40 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reach_x40", 128'(x1), 128'(40));
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        sb.delete();
        p = model(1, 3, rnd_tt, 40, rnd_tt);
        checkOutput("abort_busy", 128'(busy1), '0);
        checkOutput("abort_x", 128'(x1), '0);
        checkOutput("abort_valid", 128'(valid1), '0);
        checkOutput("abort_tt", tt1, p.tt);
        checkOutput("abort_ones", 128'(ones1), 128'(p.ones));
        checkOutput("abort_match", 128'(match1), '0);
        repeat (400) @(negedge clk);

        $display("[TB] asynchronous reset mid-sweep");
        applyStimulus(1, 2, MAJ_SIG, 1'b0);
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        sb.delete();
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 2, MAJ_SIG, 1'b0);
        waitResult(1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
